// File: rtl/key_window_sched_pkg.sv
// Shared types and sizing helpers for the key window scheduler.
package key_sched_pkg;

  typedef enum logic [1:0] {EMPTY, PARTIAL, READY, RUN} sched_state_e;

  localparam int DEF_KEY_W    = 7;
  localparam int DEF_NUM_KEYS = 2;
  localparam int DEF_WINDOW   = 4;

  function automatic int ph_width(input int num_keys, input int window);
    return (num_keys * window <= 2) ? 1 : $clog2(num_keys * window);
  endfunction

  function automatic int idx_width(input int num_keys);
    return (num_keys <= 2) ? 1 : $clog2(num_keys);
  endfunction

endpackage

// File: rtl/key_window_sched_phase_ctr.sv
// Modulo-(NUM_KEYS*WINDOW) phase counter, falling-edge, mirroring the locked core's window counter.
module key_phase_ctr
  import key_sched_pkg::*;
#(
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int WINDOW   = DEF_WINDOW,
  localparam int PH_W    = ph_width(NUM_KEYS, WINDOW),
  localparam int IDX_W   = idx_width(NUM_KEYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [PH_W-1:0]  phase,
  output logic [IDX_W-1:0] idx
);

  localparam logic [PH_W-1:0] LAST = PH_W'(NUM_KEYS * WINDOW - 1);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PH_W'(1);
    end
  end

  assign idx = IDX_W'(phase / PH_W'(WINDOW));

endmodule

// File: rtl/key_window_sched.sv
// Stores NUM_KEYS key words and, once armed, presents one per WINDOW-cycle slot to the locked core.
module key_window_sched
  import key_sched_pkg::*;
#(
  parameter int KEY_W    = DEF_KEY_W,
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int WINDOW   = DEF_WINDOW,
  localparam int PH_W    = ph_width(NUM_KEYS, WINDOW),
  localparam int IDX_W   = idx_width(NUM_KEYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [KEY_W-1:0] load_key,
  input  logic             arm,
  input  logic             disarm,
  input  logic             resync,
  output logic [KEY_W-1:0] key_out,
  output logic [IDX_W-1:0] key_idx,
  output logic [PH_W-1:0]  phase,
  output logic             armed
);

  sched_state_e        state, state_nxt;
  logic [KEY_W-1:0]    slots [NUM_KEYS];
  logic [NUM_KEYS-1:0] loaded, loaded_nxt;
  logic                load_acc;
  logic                ctr_clr, ctr_en;
  logic [IDX_W-1:0]    ctr_idx;

  assign load_ready = (state != RUN);
  assign load_acc   = load_valid && load_ready && (32'(load_idx) < NUM_KEYS);

  always_comb begin
    loaded_nxt = loaded;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (load_acc && (load_idx == IDX_W'(k))) loaded_nxt[k] = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded <= '0;
      for (int k = 0; k < NUM_KEYS; k++) slots[k] <= '0;
    end else begin
      loaded <= loaded_nxt;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (load_acc && (load_idx == IDX_W'(k))) slots[k] <= load_key;
      end
    end
  end

  // disarm outranks arm; resync only touches the phase counter
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY, PARTIAL: if (load_acc) state_nxt = (&loaded_nxt) ? READY : PARTIAL;
      READY:          if (arm && !disarm) state_nxt = RUN;
      RUN:            if (disarm) state_nxt = READY;
      default:        state_nxt = EMPTY;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  assign ctr_clr = resync || ((state != RUN) && (state_nxt == RUN));
  assign ctr_en  = (state == RUN) && (state_nxt == RUN);

  key_phase_ctr #(
    .NUM_KEYS (NUM_KEYS),
    .WINDOW   (WINDOW)
  ) u_phase_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .phase (phase),
    .idx   (ctr_idx)
  );

  // Slots are frozen while in RUN, so these follow the registered state/phase edge-for-edge.
  assign armed   = (state == RUN);
  assign key_idx = armed ? ctr_idx : '0;
  assign key_out = armed ? slots[ctr_idx] : '0;

endmodule

// File: tb/tb_key_window_sched.sv
// Scoreboard bench: stimulus queues expected key/idx/phase, monitors pop while armed.
module tb_key_window_sched;

  typedef struct packed {
    logic [6:0] key;
    logic [1:0] idx;
    logic [2:0] phase;
  } exp_t;

  logic clk;
  logic rst_n;

  logic       load_valid_a, load_ready_a, arm_a, disarm_a, resync_a, armed_a;
  logic [0:0] load_idx_a, key_idx_a;
  logic [6:0] load_key_a, key_out_a;
  logic [2:0] phase_a;

  logic       load_valid_b, load_ready_b, arm_b, disarm_b, resync_b, armed_b;
  logic [1:0] load_idx_b, key_idx_b;
  logic [6:0] load_key_b, key_out_b;
  logic [2:0] phase_b;

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t exp_a, act_a, exp_b, act_b;

  int t6_key [7] = '{'h11, 'h11, 'h22, 'h22, 'h33, 'h33, 'h11};
  int t6_idx [7] = '{0, 0, 1, 1, 2, 2, 0};
  int t6_ph  [7] = '{0, 1, 2, 3, 4, 5, 0};

  key_window_sched dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid_a),
    .load_ready (load_ready_a),
    .load_idx   (load_idx_a),
    .load_key   (load_key_a),
    .arm        (arm_a),
    .disarm     (disarm_a),
    .resync     (resync_a),
    .key_out    (key_out_a),
    .key_idx    (key_idx_a),
    .phase      (phase_a),
    .armed      (armed_a)
  );

  key_window_sched #(.KEY_W(7), .NUM_KEYS(3), .WINDOW(2)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid_b),
    .load_ready (load_ready_b),
    .load_idx   (load_idx_b),
    .load_key   (load_key_b),
    .arm        (arm_b),
    .disarm     (disarm_b),
    .resync     (resync_b),
    .key_out    (key_out_b),
    .key_idx    (key_idx_b),
    .phase      (phase_b),
    .armed      (armed_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
  endtask

  task automatic push_a(input int key, input int idx, input int ph);
    exp_t e;
    e.key = 7'(key); e.idx = 2'(idx); e.phase = 3'(ph);
    q_a.push_back(e);
  endtask

  task automatic push_b(input int key, input int idx, input int ph);
    exp_t e;
    e.key = 7'(key); e.idx = 2'(idx); e.phase = 3'(ph);
    q_b.push_back(e);
  endtask

  task automatic load_a(input int idx, input int key);
    load_valid_a = 1'b1; load_idx_a = 1'(idx); load_key_a = 7'(key);
    tick();
    load_valid_a = 1'b0;
  endtask

  task automatic load_b(input int idx, input int key);
    load_valid_b = 1'b1; load_idx_b = 2'(idx); load_key_b = 7'(key);
    tick();
    load_valid_b = 1'b0;
  endtask

  task automatic pulse_a(input int which);
    if (which == 0) arm_a = 1'b1;
    else if (which == 1) disarm_a = 1'b1;
    else resync_a = 1'b1;
    tick();
    arm_a = 1'b0; disarm_a = 1'b0; resync_a = 1'b0;
  endtask

  task automatic pulse_b(input int which);
    if (which == 0) arm_b = 1'b1;
    else disarm_b = 1'b1;
    tick();
    arm_b = 1'b0; disarm_b = 1'b0;
  endtask

  always @(posedge clk) begin
    if (armed_a === 1'b1) begin
      act_a.key = key_out_a; act_a.idx = 2'(key_idx_a); act_a.phase = phase_a;
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL run_a_unexpected: got %0h, required no output", act_a);
      end else begin
        exp_a = q_a.pop_front();
        check_output("run_a {key,idx,phase}", 32'(act_a), 32'(exp_a));
      end
    end
  end

  always @(posedge clk) begin
    if (armed_b === 1'b1) begin
      act_b.key = key_out_b; act_b.idx = key_idx_b; act_b.phase = phase_b;
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL run_b_unexpected: got %0h, required no output", act_b);
      end else begin
        exp_b = q_b.pop_front();
        check_output("run_b {key,idx,phase}", 32'(act_b), 32'(exp_b));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    load_valid_a = 0; load_idx_a = 0; load_key_a = 0; arm_a = 0; disarm_a = 0; resync_a = 0;
    load_valid_b = 0; load_idx_b = 0; load_key_b = 0; arm_b = 0; disarm_b = 0; resync_b = 0;
    tick(); tick();
    check_output("rst_key_out", 32'(key_out_a), 0);
    check_output("rst_key_idx", 32'(key_idx_a), 0);
    check_output("rst_phase", 32'(phase_a), 0);
    check_output("rst_armed", 32'(armed_a), 0);
    check_output("rst_load_ready", 32'(load_ready_a), 1);
    rst_n = 1'b1;

    // Full two-slot cycle, 16 cycles with wrap
    load_a(0, 'h49);
    load_a(1, 'h29);
    check_output("ready_not_armed", 32'(armed_a), 0);
    for (int i = 0; i < 16; i++) push_a(((i % 8) < 4) ? 'h49 : 'h29, (i % 8) / 4, i % 8);
    pulse_a(0);
    repeat (15) tick();
    pulse_a(1);
    check_output("disarm_armed", 32'(armed_a), 0);
    check_output("disarm_key_out", 32'(key_out_a), 0);
    check_output("disarm_key_idx", 32'(key_idx_a), 0);
    check_output("disarm_phase_held", 32'(phase_a), 7);
    check_output("disarm_load_ready", 32'(load_ready_a), 1);
    pulse_a(2);
    check_output("resync_idle_phase", 32'(phase_a), 0);
    check_output("resync_idle_armed", 32'(armed_a), 0);

    // resync at phase 6, then resync+disarm together
    for (int p = 0; p < 7; p++) push_a((p < 4) ? 'h49 : 'h29, p / 4, p);
    push_a('h49, 0, 0);
    for (int p = 1; p < 7; p++) push_a((p < 4) ? 'h49 : 'h29, p / 4, p);
    pulse_a(0);
    repeat (6) tick();
    pulse_a(2);
    repeat (6) tick();
    resync_a = 1'b1; disarm_a = 1'b1;
    tick();
    resync_a = 1'b0; disarm_a = 1'b0;
    check_output("resync_disarm_armed", 32'(armed_a), 0);
    check_output("resync_disarm_phase", 32'(phase_a), 0);
    check_output("resync_disarm_key_out", 32'(key_out_a), 0);

    // load attempt while running is refused
    push_a('h49, 0, 0); push_a('h49, 0, 1); push_a('h49, 0, 2);
    pulse_a(0);
    check_output("run_load_ready", 32'(load_ready_a), 0);
    load_a(0, 'h7F);
    tick();
    pulse_a(1);
    for (int p = 0; p < 6; p++) push_a((p < 4) ? 'h49 : 'h29, p / 4, p);
    pulse_a(0);
    repeat (5) tick();

    // async reset between edges at phase 5
    #1 rst_n = 1'b0;
    #1;
    check_output("async_rst_key_out", 32'(key_out_a), 0);
    check_output("async_rst_armed", 32'(armed_a), 0);
    check_output("async_rst_phase", 32'(phase_a), 0);
    tick();
    rst_n = 1'b1;
    pulse_a(0);
    check_output("arm_empty_ignored", 32'(armed_a), 0);
    load_a(0, 'h49);
    pulse_a(0);
    check_output("arm_partial_ignored", 32'(armed_a), 0);
    check_output("arm_partial_key_out", 32'(key_out_a), 0);
    load_a(1, 'h29);
    for (int p = 0; p < 4; p++) push_a('h49, 0, p);
    pulse_a(0);
    repeat (3) tick();
    pulse_a(1);

    // load and arm on the same edge in READY
    push_a('h55, 0, 0); push_a('h55, 0, 1);
    load_valid_a = 1'b1; load_idx_a = 1'b0; load_key_a = 7'h55; arm_a = 1'b1;
    tick();
    load_valid_a = 1'b0; arm_a = 1'b0;
    tick();
    pulse_a(1);

    // Three-slot instance, WINDOW=2, out-of-range index ignored
    load_b(0, 'h11);
    load_b(1, 'h22);
    load_b(3, 'h44);
    pulse_b(0);
    check_output("b_arm_partial_ignored", 32'(armed_b), 0);
    check_output("b_partial_key_out", 32'(key_out_b), 0);
    load_b(2, 'h33);
    for (int i = 0; i < 7; i++) push_b(t6_key[i], t6_idx[i], t6_ph[i]);
    pulse_b(0);
    repeat (6) tick();
    pulse_b(1);
    check_output("b_disarm_armed", 32'(armed_b), 0);

    tick();
    check_output("q_a_drained", 32'(q_a.size()), 0);
    check_output("q_b_drained", 32'(q_b.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
